// File: rtl/byte_deser.sv
// byte_deser: receive-side byte-to-word deserializer.
//
// Collects a stream of 8-bit bytes and reassembles them into NUM_BYTES-wide
// words. A start-of-word marker (sof) aligns the assembler to word
// boundaries. Each completed word goes into an output register with a
// valid/ready handshake. Overrun and misalignment errors are flagged with
// sticky bits.
//
// Parameters:
//   NUM_BYTES  bytes per output word (>=1), word width W = 8*NUM_BYTES
//   LSB_FIRST  1: byte k lands in word[8k+7:8k]
//              0: byte k lands in word[W-1-8k -: 8]
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous active-high reset
//   byte_in     in   8      incoming byte
//   byte_valid  in   1      byte_in is valid this cycle
//   sof         in   1      with byte_valid, byte_in is byte 0 of a word
//   word_ready  in   1      downstream accepts bytes_out this cycle
//   clr_err     in   1      clears overrun and sync_err
//   bytes_out   out  W      assembled word, stable while word_valid=1
//   word_valid  out  1      bytes_out holds an unaccepted word
//   byte_num    out  IDX_W  index of the next expected byte
//   locked      out  1      high once word alignment has been found
//   overrun     out  1      sticky: a completed word was dropped
//   sync_err    out  1      sticky: sof arrived in the middle of a word
module byte_deser #(
  parameter int NUM_BYTES = 4,
  parameter bit LSB_FIRST = 1'b1,
  localparam int W     = 8 * NUM_BYTES,
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             sof,
  input  logic             word_ready,
  input  logic             clr_err,
  output logic [W-1:0]     bytes_out,
  output logic             word_valid,
  output logic [IDX_W-1:0] byte_num,
  output logic             locked,
  output logic             overrun,
  output logic             sync_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic {
    HUNT,
    COLLECT
  } state_t;

  state_t         state;
  logic [W-1:0]   asm_q;
  logic [W-1:0]   asm_next;
  logic [IDX_W-1:0] eff_idx;
  logic           accept;
  logic           complete;
  logic           sync_hit;

  // Work out which lane the current byte belongs in.
  // A sof always forces lane 0. That covers both the initial lock and
  // realignment in the middle of a word.
  // Starting a word from lane 0 throws away any partial content, so a
  // word never mixes lanes from two different words.
  always_comb begin
    accept   = byte_valid & ((state == COLLECT) | sof);
    eff_idx  = ((state == HUNT) || sof) ? '0 : byte_num;
    complete = accept & (eff_idx == LAST_IDX);
    sync_hit = byte_valid & sof & (state == COLLECT) & (byte_num != '0);
    asm_next = (eff_idx == '0) ? '0 : asm_q;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (eff_idx == IDX_W'(k)) begin
        if (LSB_FIRST)
          asm_next[8*k +: 8] = byte_in;
        else
          asm_next[W-8-8*k +: 8] = byte_in;
      end
    end
  end

  // Alignment FSM, assembly register and output register.
  // A completed word goes straight into bytes_out on the same edge that
  // captures its last byte, as long as the output slot is free or is
  // being drained on this edge. Otherwise the word is dropped and
  // overrun is set.
  // A new error on the same edge as clr_err wins, so the flag stays set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      byte_num   <= '0;
      asm_q      <= '0;
      bytes_out  <= '0;
      word_valid <= 1'b0;
      locked     <= 1'b0;
      overrun    <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      case (state)
        HUNT: begin
          if (accept) begin
            state  <= COLLECT;
            locked <= 1'b1;
          end
        end
        COLLECT: begin
          state  <= COLLECT;
          locked <= 1'b1;
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase

      if (accept) begin
        if (complete) begin
          asm_q    <= '0;
          byte_num <= '0;
        end else begin
          asm_q    <= asm_next;
          byte_num <= eff_idx + 1'b1;
        end
      end

      if (complete && (!word_valid || word_ready)) begin
        bytes_out  <= asm_next;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end

      overrun  <= (complete & word_valid & ~word_ready) | (overrun & ~clr_err);
      sync_err <= sync_hit | (sync_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_byte_deser.sv
// tb_byte_deser: self-checking bench for byte_deser.
//
// Three instances share one input stream:
//   u0  4 bytes per word, LSB first
//   u1  4 bytes per word, MSB first
//   u2  1 byte per word
// Each instance is compared every cycle against a reference model that
// keeps the received bytes of the current word in an array. The model
// builds each finished word with plain shifts. Directed sequences are
// followed by a randomized run with occasional asynchronous resets.
module tb_byte_deser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        sof;
  logic        word_ready;
  logic        clr_err;

  logic [31:0] dout_a, dout_b;
  logic [7:0]  dout_c;
  logic        wv_a, wv_b, wv_c;
  logic [1:0]  bn_a, bn_b;
  logic [0:0]  bn_c;
  logic        lk_a, lk_b, lk_c;
  logic        ov_a, ov_b, ov_c;
  logic        se_a, se_b, se_c;

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance.
  int          nb  [3] = '{4, 4, 1};
  bit          lsb [3] = '{1'b1, 1'b0, 1'b1};
  logic [7:0]  part[3][4];
  int          cnt [3];
  bit          mlock[3], mvalid[3], movr[3], mserr[3];
  logic [31:0] mword[3];

  always #5 clk = ~clk;

  byte_deser #(.NUM_BYTES(4), .LSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .sof(sof),
    .word_ready(word_ready), .clr_err(clr_err), .bytes_out(dout_a), .word_valid(wv_a),
    .byte_num(bn_a), .locked(lk_a), .overrun(ov_a), .sync_err(se_a));

  byte_deser #(.NUM_BYTES(4), .LSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .sof(sof),
    .word_ready(word_ready), .clr_err(clr_err), .bytes_out(dout_b), .word_valid(wv_b),
    .byte_num(bn_b), .locked(lk_b), .overrun(ov_b), .sync_err(se_b));

  byte_deser #(.NUM_BYTES(1), .LSB_FIRST(1'b1)) u2 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .sof(sof),
    .word_ready(word_ready), .clr_err(clr_err), .bytes_out(dout_c), .word_valid(wv_c),
    .byte_num(bn_c), .locked(lk_c), .overrun(ov_c), .sync_err(se_c));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      cnt[i]    = 0;
      mlock[i]  = 1'b0;
      mvalid[i] = 1'b0;
      movr[i]   = 1'b0;
      mserr[i]  = 1'b0;
      mword[i]  = '0;
      for (int k = 0; k < 4; k++) part[i][k] = '0;
    end
  endtask

  // Apply one clock edge's worth of input to the model for instance i.
  task automatic modelStep(input int i);
    logic [31:0] w;
    bit done, ovr_set, serr_set;
    w = '0;
    done = 1'b0;
    serr_set = 1'b0;
    if (byte_valid && (mlock[i] || sof)) begin
      if (mlock[i] && sof && cnt[i] != 0) serr_set = 1'b1;
      if (sof) cnt[i] = 0;
      part[i][cnt[i]] = byte_in;
      cnt[i]++;
      mlock[i] = 1'b1;
      if (cnt[i] == nb[i]) begin
        for (int k = 0; k < nb[i]; k++) begin
          if (lsb[i]) w = w | (32'(part[i][k]) << (8 * k));
          else        w = w | (32'(part[i][k]) << (8 * (nb[i] - 1 - k)));
        end
        cnt[i] = 0;
        done = 1'b1;
      end
    end
    ovr_set = done && mvalid[i] && !word_ready;
    if (done && (!mvalid[i] || word_ready)) begin
      mword[i]  = w;
      mvalid[i] = 1'b1;
    end else if (mvalid[i] && word_ready) begin
      mvalid[i] = 1'b0;
    end
    movr[i]  = ovr_set  ? 1'b1 : (clr_err ? 1'b0 : movr[i]);
    mserr[i] = serr_set ? 1'b1 : (clr_err ? 1'b0 : mserr[i]);
  endtask

  task automatic checkInst(input int i, input logic [31:0] bo, input logic wv,
                           input logic [31:0] bn, input logic lk, input logic ov,
                           input logic se);
    checkOutput($sformatf("u%0d.word_valid", i), 32'(wv), 32'(mvalid[i]));
    if (mvalid[i] || !mlock[i])
      checkOutput($sformatf("u%0d.bytes_out", i), bo, mword[i]);
    checkOutput($sformatf("u%0d.byte_num", i), bn, 32'(cnt[i]));
    checkOutput($sformatf("u%0d.locked", i), 32'(lk), 32'(mlock[i]));
    checkOutput($sformatf("u%0d.overrun", i), 32'(ov), 32'(movr[i]));
    checkOutput($sformatf("u%0d.sync_err", i), 32'(se), 32'(mserr[i]));
  endtask

  task automatic checkAll();
    checkInst(0, dout_a, wv_a, 32'(bn_a), lk_a, ov_a, se_a);
    checkInst(1, dout_b, wv_b, 32'(bn_b), lk_b, ov_b, se_b);
    checkInst(2, {24'b0, dout_c}, wv_c, 32'(bn_c), lk_c, ov_c, se_c);
  endtask

  // Drive one cycle of byte input, step the models at the edge, check after it.
  task automatic applyStimulus(input logic v, input logic [7:0] b, input logic s);
    @(negedge clk);
    byte_valid = v;
    byte_in    = b;
    sof        = s;
    @(posedge clk);
    for (int i = 0; i < 3; i++) modelStep(i);
    #1;
    checkAll();
  endtask

  // Assert reset between edges and check that the outputs clear without a clock edge.
  task automatic doReset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    byte_in    = '0;
    byte_valid = 1'b0;
    sof        = 1'b0;
    word_ready = 1'b1;
    clr_err    = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] hunt: bytes before the first sof are dropped");
    applyStimulus(1'b1, 8'hAA, 1'b0);
    applyStimulus(1'b1, 8'hBB, 1'b0);
    applyStimulus(1'b1, 8'h01, 1'b1);
    applyStimulus(1'b1, 8'h02, 1'b0);
    applyStimulus(1'b1, 8'h03, 1'b0);
    applyStimulus(1'b1, 8'h04, 1'b0);
    checkOutput("T2 word", dout_a, 32'h04030201);

    $display("[TB] back-to-back word, both byte orders");
    applyStimulus(1'b1, 8'h11, 1'b1);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0);
    checkOutput("T1 lsb word", dout_a, 32'h44332211);
    checkOutput("T5 msb word", dout_b, 32'h11223344);
    checkOutput("T1 byte_num", 32'(bn_a), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("T1 valid drop", 32'(wv_a), 32'd0);

    $display("[TB] overrun with output held");
    word_ready = 1'b0;
    for (int k = 1; k <= 8; k++)
      applyStimulus(1'b1, 8'(k), (k == 1) || (k == 5));
    checkOutput("T3 held word", dout_a, 32'h04030201);
    checkOutput("T3 overrun", 32'(ov_a), 32'd1);
    word_ready = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("T3 popped", 32'(wv_a), 32'd0);
    clr_err = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    clr_err = 1'b0;
    checkOutput("T3 overrun clr", 32'(ov_a), 32'd0);

    $display("[TB] realign on sof in mid-word");
    applyStimulus(1'b1, 8'h11, 1'b1);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b1);
    applyStimulus(1'b1, 8'h44, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b0);
    applyStimulus(1'b1, 8'h66, 1'b0);
    checkOutput("T4 word", dout_a, 32'h66554433);
    checkOutput("T4 sync_err", 32'(se_a), 32'd1);
    clr_err = 1'b1;
    applyStimulus(1'b1, 8'h77, 1'b1);
    clr_err = 1'b0;

    $display("[TB] async reset in mid-word");
    applyStimulus(1'b1, 8'h99, 1'b0);
    doReset();
    applyStimulus(1'b1, 8'hA1, 1'b1);
    applyStimulus(1'b1, 8'hB2, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b0);
    applyStimulus(1'b1, 8'hD4, 1'b0);
    checkOutput("T6 word", dout_a, 32'hD4C3B2A1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      word_ready = ($urandom_range(0, 3) != 0);
      clr_err    = ($urandom_range(0, 15) == 0);
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0);
      if (n % 700 == 699) doReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
